// File: rtl/des_ip_pair_if.sv
// rtl/des_ip_pair_if.sv - block/result bus for the DES IP / IP^-1 pair
interface des_ip_pair_if;
  logic [63:0] data_in;
  logic        in_valid;
  logic [63:0] ip_out;
  logic [63:0] ip_inv_out;
  logic        out_valid;

  modport master (
    output data_in, in_valid,
    input  ip_out, ip_inv_out, out_valid
  );

  modport slave (
    input  data_in, in_valid,
    output ip_out, ip_inv_out, out_valid
  );
endinterface

// File: rtl/des_ip_pair.sv
// rtl/des_ip_pair.sv - DES initial permutation, its inverse, and a registered wrapper
// Bit position k (1..64, MSB first) lives at vector index 64-k.
module IP (
  input  logic [63:0] d_i,
  output logic [63:0] d_o
);
  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      localparam int SRC = (r < 4) ? (58 + 2*r - 8*c) : (57 + 2*(r-4) - 8*c);
      assign d_o[63-(8*r+c)] = d_i[64-SRC];
    end
  end
endmodule

module inv_IP (
  input  logic [63:0] d_i,
  output logic [63:0] d_o
);
  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      localparam int SRC = (c % 2 == 0) ? (40 - r + 4*c) : (8 - r + 4*(c-1));
      assign d_o[63-(8*r+c)] = d_i[64-SRC];
    end
  end
endmodule

module des_ip_pair (
  input  logic             clk,
  input  logic             rst_n,
  des_ip_pair_if.slave     bus_if
);
  logic [63:0] ip_w;
  logic [63:0] fp_w;
  logic [63:0] ip_q, ip_d;
  logic [63:0] inv_q, inv_d;
  logic        valid_q, valid_d;

  IP u_ip (
    .d_i (bus_if.data_in),
    .d_o (ip_w)
  );

  // Round-trip path: inverse is fed from the forward permutation, not data_in.
  inv_IP u_inv_ip (
    .d_i (ip_w),
    .d_o (fp_w)
  );

  always_comb begin
    ip_d    = ip_q;
    inv_d   = inv_q;
    valid_d = bus_if.in_valid;
    if (bus_if.in_valid) begin
      ip_d  = ip_w;
      inv_d = fp_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q    <= '0;
      inv_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ip_q    <= ip_d;
      inv_q   <= inv_d;
      valid_q <= valid_d;
    end
  end

  assign bus_if.ip_out     = ip_q;
  assign bus_if.ip_inv_out = inv_q;
  assign bus_if.out_valid  = valid_q;
endmodule

// File: tb/tb_des_ip_pair.sv
// tb/tb_des_ip_pair.sv - scoreboard bench for des_ip_pair
module tb_des_ip_pair;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_ip_pair_if bus ();

  des_ip_pair dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  logic [63:0] fp_in;
  logic [63:0] fp_out;
  inv_IP u_fp (
    .d_i (fp_in),
    .d_o (fp_out)
  );

  typedef struct packed {
    logic [63:0] ip;
    logic [63:0] inv;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Standard published DES IP table, row-major, DES bit numbering.
  int ip_t [64] = '{58,50,42,34,26,18,10,2,  60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6,  64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17, 9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5,  63,55,47,39,31,23,15,7};

  function automatic logic [63:0] model_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int p = 1; p <= 64; p++) y[64-p] = x[64-ip_t[p-1]];
    return y;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [63:0] d);
    exp_t e;
    bus.in_valid = v;
    bus.data_in  = d;
    if (v) exp_q.push_back('{model_ip(d), d});
    @(posedge clk);
    #1;
    check("out_valid", 64'(bus.out_valid), 64'(v));
    if (v) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("ip_out", bus.ip_out, e.ip);
        check("ip_inv_out", bus.ip_inv_out, e.inv);
        check("popcount", 64'($countones(bus.ip_out)), 64'($countones(d)));
        last_e = e;
      end
    end else begin
      check("hold_ip", bus.ip_out, last_e.ip);
      check("hold_inv", bus.ip_inv_out, last_e.inv);
    end
  endtask

  logic [63:0] rot;

  initial begin
    last_e       = '0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.data_in  = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ip", bus.ip_out, 64'd0);
    check("rst_inv", bus.ip_inv_out, 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    cycle(1'b1, 64'h0123456789ABCDEF);
    check("known_ip", bus.ip_out, 64'hCC00CCFFF0AAF0AA);
    check("known_inv", bus.ip_inv_out, 64'h0123456789ABCDEF);
    cycle(1'b1, 64'h8000000000000000);
    check("bit1_ip", bus.ip_out, 64'h0000000001000000);
    cycle(1'b1, 64'd0);
    check("zero_ip", bus.ip_out, 64'd0);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("ones_ip", bus.ip_out, 64'hFFFF_FFFF_FFFF_FFFF);

    rot = 64'h0123456789ABCDEF;
    for (int i = 0; i <= 16; i++) begin
      cycle(1'b1, rot);
      check("rot_pop32", 64'($countones(bus.ip_out)), 64'd32);
      rot = {rot[59:0], rot[63:60]};
    end

    cycle(1'b1, 64'hDEADBEEF_CAFEF00D);
    repeat (3) cycle(1'b0, 64'h5555_5555_5555_5555);

    for (int i = 0; i < 1000; i++) cycle(1'b1, {$urandom, $urandom});

    fp_in = 64'hCC00CCFFF0AAF0AA;
    #1;
    check("standalone_inv", fp_out, 64'h0123456789ABCDEF);

    // Asynchronous reset mid-cycle with a valid input pending.
    bus.in_valid = 1'b1;
    bus.data_in  = 64'h1122334455667788;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ip", bus.ip_out, 64'd0);
    check("async_rst_inv", bus.ip_inv_out, 64'd0);
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_ip", bus.ip_out, 64'd0);
    check("held_rst_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    last_e = '0;
    cycle(1'b0, 64'h0);
    cycle(1'b1, 64'h0F0F_0F0F_F0F0_F0F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/des_ip_pair.md
Name:
des_ip_pair

Overview:
- Registered wrapper around the DES Initial Permutation (IP) and its inverse (IP⁻¹, the final permutation).
- Two combinational submodules: `IP` and `inv_IP`. The top registers their results.
- Outputs are the IP of the input block and the IP⁻¹ of that result. The second output is a round-trip self-check that must reproduce the input.
- Sits at the entry and exit of the DES Feistel datapath.

Parameters:
- None. Block width is fixed at 64 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  64  plaintext/state block; DES bit 1 = data_in[63], DES bit 64 = data_in[0].
- in_valid  input  1  data_in is sampled on this clock edge.
- ip_out  output  64  registered IP(data_in).
- ip_inv_out  output  64  registered inv_IP(IP(data_in)); equals the sampled data_in.
- out_valid  output  1  ip_out and ip_inv_out hold a new result.

Behaviour:
- Bit numbering is DES convention: position k (1..64) counts from the MSB, so position k = bit [64-k].
- IP rule: output position p = 8r+c+1 (r,c in 0..7) takes input position IP[r][c].
  - For r<4: IP[r][c] = 58+2r-8c.
  - For r>=4: IP[r][c] = 57+2(r-4)-8c.
  - First row is therefore 58 50 42 34 26 18 10 2; last row is 63 55 47 39 31 23 15 7.
- inv_IP rule: output position p = 8r+c+1 takes input position FP[r][c].
  - For even c: FP[r][c] = 40-r+4c.
  - For odd c: FP[r][c] = 8-r+4(c-1).
  - First row is therefore 40 8 48 16 56 24 64 32.
- inv_IP is the exact inverse of IP: inv_IP(IP(x)) = x for every x.
- Both permutations are pure wiring with no logic gates. Each submodule is purely combinational.
- In the top, inv_IP is fed by the IP submodule's combinational output, not by data_in directly.
- Latency is 1 clock. When in_valid=1 at a rising edge:
  - ip_out <= IP(data_in)
  - ip_inv_out <= inv_IP(IP(data_in))
  - out_valid <= 1
- When in_valid=0 at a rising edge, out_valid <= 0 and ip_out/ip_inv_out hold their previous values.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure and no internal buffering beyond the one output stage.
- Reset:
  - rst_n low immediately (asynchronously) forces ip_out=0, ip_inv_out=0, out_valid=0.
  - The block stays in that state while rst_n is low.
  - A valid input presented during reset is discarded.
  - The first sampling edge is the first rising edge at which rst_n is high.
- Reset mid-stream: an in-flight result is lost, and outputs read zero until the next valid input.
- Invariants:
  - IP(0) = 0 and IP(all ones) = all ones.
  - The population count of ip_out equals that of the sampled data_in.
- X-free: no output depends on uninitialised state after reset.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with in_valid=1 -> ip_out, ip_inv_out and out_valid go to 0 immediately with no clock edge, and stay 0 while reset is held.
- Known vector: data_in=64'h0123456789ABCDEF, in_valid=1 -> one clock later ip_out=64'hCC00CCFFF0AAF0AA, ip_inv_out=64'h0123456789ABCDEF, out_valid=1.
- Single-bit routing: data_in=64'h8000000000000000 -> ip_out=64'h0000000001000000. Also data_in=0 -> ip_out=0, and data_in=64'hFFFFFFFFFFFFFFFF -> ip_out=64'hFFFFFFFFFFFFFFFF.
- Rotation sweep: start at 64'h0123456789ABCDEF and apply 16 consecutive circular left-by-4 rotations, one per cycle with in_valid=1 continuously. Each cycle: ip_inv_out equals the data_in of the previous cycle, popcount(ip_out)=32, and out_valid stays 1.
- Inverse check: drive 1000 random vectors -> ip_inv_out equals the input every time, and inv_IP(64'hCC00CCFFF0AAF0AA) on the standalone submodule = 64'h0123456789ABCDEF.
- Hold behaviour: valid input, then in_valid=0 for 3 cycles -> out_valid drops to 0 and ip_out/ip_inv_out keep the last values.
